// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives the instruction ROM and loads the IF/ID register.
// Define IF_DELAY_SLOT_EN to let the delay-slot instruction through on a taken redirect.
module if_fetch_unit #(
  parameter int unsigned          ADDR_W   = 32,
  parameter int unsigned          DATA_W   = 32,
  parameter logic [ADDR_W-1:0]    RESET_PC = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall_if,
  input  logic              stall_id,
  input  logic              flush,
  input  logic [ADDR_W-1:0] new_pc,
  input  logic              branch_flag,
  input  logic [ADDR_W-1:0] branch_target,
  output logic              rom_ce,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_inst,
  output logic [ADDR_W-1:0] id_pc,
  output logic [DATA_W-1:0] id_inst,
  output logic              id_valid,
  output logic              id_adel
);

  logic              rom_ce_q, rom_ce_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              pend_v_q, pend_v_d;
  logic [ADDR_W-1:0] pend_pc_q, pend_pc_d;
  logic [ADDR_W-1:0] id_pc_q, id_pc_d;
  logic [DATA_W-1:0] id_inst_q, id_inst_d;
  logic              id_valid_q, id_valid_d;
  logic              id_adel_q, id_adel_d;
  logic              redirect;
  logic              squash;
  logic              misaligned;

  assign misaligned = |pc_q[1:0];

`ifdef IF_DELAY_SLOT_EN
  assign squash = 1'b0;
`else
  assign squash = redirect;
`endif

  always_comb begin
    rom_ce_d   = 1'b1;
    pc_d       = pc_q;
    pend_v_d   = pend_v_q;
    pend_pc_d  = pend_pc_q;
    id_pc_d    = id_pc_q;
    id_inst_d  = id_inst_q;
    id_valid_d = id_valid_q;
    id_adel_d  = id_adel_q;
    redirect   = 1'b0;

    if (!rom_ce_q) begin
      // first edge out of reset only enables the ROM; nothing has been fetched yet
      id_pc_d    = '0;
      id_inst_d  = '0;
      id_valid_d = 1'b0;
      id_adel_d  = 1'b0;
    end else if (flush) begin
      pc_d       = new_pc;
      pend_v_d   = 1'b0;
      id_pc_d    = '0;
      id_inst_d  = '0;
      id_valid_d = 1'b0;
      id_adel_d  = 1'b0;
    end else begin
      if (stall_if) begin
        if (branch_flag) begin
          pend_v_d  = 1'b1;
          pend_pc_d = branch_target;
        end
      end else if (branch_flag) begin
        pc_d     = branch_target;
        pend_v_d = 1'b0;
        redirect = 1'b1;
      end else if (pend_v_q) begin
        pc_d     = pend_pc_q;
        pend_v_d = 1'b0;
        redirect = 1'b1;
      end else begin
        pc_d = pc_q + ADDR_W'(4);
      end

      if (stall_id) begin
        id_pc_d = id_pc_q;
      end else if (stall_if || squash) begin
        id_pc_d    = '0;
        id_inst_d  = '0;
        id_valid_d = 1'b0;
        id_adel_d  = 1'b0;
      end else begin
        id_pc_d    = pc_q;
        id_inst_d  = misaligned ? '0 : rom_inst;
        id_valid_d = 1'b1;
        id_adel_d  = misaligned;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rom_ce_q   <= 1'b0;
      pc_q       <= RESET_PC;
      pend_v_q   <= 1'b0;
      pend_pc_q  <= '0;
      id_pc_q    <= '0;
      id_inst_q  <= '0;
      id_valid_q <= 1'b0;
      id_adel_q  <= 1'b0;
    end else begin
      rom_ce_q   <= rom_ce_d;
      pc_q       <= pc_d;
      pend_v_q   <= pend_v_d;
      pend_pc_q  <= pend_pc_d;
      id_pc_q    <= id_pc_d;
      id_inst_q  <= id_inst_d;
      id_valid_q <= id_valid_d;
      id_adel_q  <= id_adel_d;
    end
  end

  assign rom_ce   = rom_ce_q;
  assign rom_addr = pc_q;
  assign id_pc    = id_pc_q;
  assign id_inst  = id_inst_q;
  assign id_valid = id_valid_q;
  assign id_adel  = id_adel_q;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed vector bench for if_fetch_unit; follows IF_DELAY_SLOT_EN if defined for the build.
module tb_if_fetch_unit;

`ifdef IF_DELAY_SLOT_EN
  localparam bit DS = 1'b1;
`else
  localparam bit DS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall_if, stall_id, flush, branch_flag;
  logic [31:0] new_pc, branch_target;
  logic        rom_ce;
  logic [31:0] rom_addr, rom_inst, id_pc, id_inst;
  logic        id_valid, id_adel;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] rom_fn(input logic [31:0] a);
    return {a[15:0] ^ 16'hBEEF, a[15:0]};
  endfunction

  assign rom_inst = rom_fn(rom_addr);

  if_fetch_unit dut (
    .clk(clk), .rst_n(rst_n), .stall_if(stall_if), .stall_id(stall_id), .flush(flush),
    .new_pc(new_pc), .branch_flag(branch_flag), .branch_target(branch_target),
    .rom_ce(rom_ce), .rom_addr(rom_addr), .rom_inst(rom_inst), .id_pc(id_pc),
    .id_inst(id_inst), .id_valid(id_valid), .id_adel(id_adel)
  );

  typedef struct {
    logic        sif, sid, fl, bf;
    logic [31:0] npc, bt;
    logic [31:0] e_addr, e_pc;
    logic        e_v, e_adel;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s step %0d: got %h want %h", nm, idx, act, exp);
    end
  endtask

  task automatic add(input logic sif, input logic sid, input logic fl, input logic [31:0] npc,
                     input logic bf, input logic [31:0] bt, input logic [31:0] e_addr,
                     input logic [31:0] e_pc, input logic e_v, input logic e_adel);
    vec_t v;
    v.sif = sif; v.sid = sid; v.fl = fl; v.npc = npc; v.bf = bf; v.bt = bt;
    v.e_addr = e_addr; v.e_pc = e_pc; v.e_v = e_v; v.e_adel = e_adel;
    vecs.push_back(v);
  endtask

  task automatic idle_inputs();
    stall_if = 0; stall_id = 0; flush = 0; branch_flag = 0;
    new_pc = '0; branch_target = '0;
  endtask

  task automatic chk_reset(input int idx);
    chk("rst_rom_ce", idx, {31'd0, rom_ce}, 32'd0);
    chk("rst_rom_addr", idx, rom_addr, 32'd0);
    chk("rst_id_pc", idx, id_pc, 32'd0);
    chk("rst_id_inst", idx, id_inst, 32'd0);
    chk("rst_id_valid", idx, {31'd0, id_valid}, 32'd0);
    chk("rst_id_adel", idx, {31'd0, id_adel}, 32'd0);
  endtask

  initial begin
    logic [31:0] e_inst;
    //   sif sid fl npc           bf bt            addr          id_pc               v   adel
    add(0, 0, 0, 0,            0, 0,            32'h0,        32'h0,              0,  0);
    add(0, 0, 0, 0,            0, 0,            32'h4,        32'h0,              1,  0);
    add(0, 0, 0, 0,            0, 0,            32'h8,        32'h4,              1,  0);
    add(0, 0, 0, 0,            0, 0,            32'hC,        32'h8,              1,  0);
    add(0, 0, 0, 0,            1, 32'h40,       32'h40,       DS ? 32'hC : 32'h0, DS, 0);
    add(0, 0, 0, 0,            0, 0,            32'h44,       32'h40,             1,  0);
    add(0, 0, 0, 0,            1, 32'h10,       32'h10,       DS ? 32'h44 : 32'h0, DS, 0);
    add(1, 1, 0, 0,            0, 0,            32'h10,       DS ? 32'h44 : 32'h0, DS, 0);
    add(1, 1, 0, 0,            0, 0,            32'h10,       DS ? 32'h44 : 32'h0, DS, 0);
    add(1, 1, 0, 0,            0, 0,            32'h10,       DS ? 32'h44 : 32'h0, DS, 0);
    add(1, 0, 0, 0,            0, 0,            32'h10,       32'h0,              0,  0);
    add(0, 0, 0, 0,            0, 0,            32'h14,       32'h10,             1,  0);
    add(1, 0, 0, 0,            1, 32'h80,       32'h14,       32'h0,              0,  0);
    add(1, 0, 0, 0,            0, 0,            32'h14,       32'h0,              0,  0);
    add(0, 0, 0, 0,            0, 0,            32'h80,       DS ? 32'h14 : 32'h0, DS, 0);
    add(0, 0, 0, 0,            0, 0,            32'h84,       32'h80,             1,  0);
    add(1, 0, 1, 32'h100,      1, 32'h80,       32'h100,      32'h0,              0,  0);
    add(0, 0, 0, 0,            0, 0,            32'h104,      32'h100,            1,  0);
    add(0, 0, 0, 0,            1, 32'h42,       32'h42,       DS ? 32'h104 : 32'h0, DS, 0);
    add(0, 0, 0, 0,            0, 0,            32'h46,       32'h42,             1,  1);
    add(0, 0, 1, 32'hFFFFFFFC, 0, 0,            32'hFFFFFFFC, 32'h0,              0,  0);
    add(0, 0, 0, 0,            0, 0,            32'h0,        32'hFFFFFFFC,       1,  0);
    add(0, 0, 0, 0,            0, 0,            32'h4,        32'h0,              1,  0);
    add(1, 0, 0, 0,            1, 32'h200,      32'h4,        32'h0,              0,  0);
    add(1, 0, 0, 0,            1, 32'h300,      32'h4,        32'h0,              0,  0);
    add(0, 0, 0, 0,            0, 0,            32'h300,      DS ? 32'h4 : 32'h0, DS, 0);
    add(0, 0, 0, 0,            0, 0,            32'h304,      32'h300,            1,  0);
    add(0, 1, 0, 0,            0, 0,            32'h308,      32'h300,            1,  0);

    idle_inputs();
    rst_n = 1'b0;
    #2;
    chk_reset(-1);

    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("ce_before_first_edge", -1, {31'd0, rom_ce}, 32'd0);

    foreach (vecs[i]) begin
      stall_if = vecs[i].sif; stall_id = vecs[i].sid; flush = vecs[i].fl;
      new_pc = vecs[i].npc; branch_flag = vecs[i].bf; branch_target = vecs[i].bt;
      @(posedge clk);
      #1;
      e_inst = (vecs[i].e_v && !vecs[i].e_adel) ? rom_fn(vecs[i].e_pc) : 32'd0;
      chk("rom_ce", i, {31'd0, rom_ce}, 32'd1);
      chk("rom_addr", i, rom_addr, vecs[i].e_addr);
      chk("id_pc", i, id_pc, vecs[i].e_pc);
      chk("id_valid", i, {31'd0, id_valid}, {31'd0, vecs[i].e_v});
      chk("id_adel", i, {31'd0, id_adel}, {31'd0, vecs[i].e_adel});
      chk("id_inst", i, id_inst, e_inst);
      @(negedge clk);
    end

    // asynchronous reset mid-cycle, then restart and reset again at pc=0xC
    idle_inputs();
    rst_n = 1'b0;
    #1;
    chk_reset(100);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("restart_rom_addr", 101, rom_addr, 32'hC);
    chk("restart_id_pc", 101, id_pc, 32'h8);
    chk("restart_id_valid", 101, {31'd0, id_valid}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset(102);
    @(posedge clk);
    #1;
    chk("held_in_reset_ce", 103, {31'd0, rom_ce}, 32'd0);
    chk("held_in_reset_addr", 103, rom_addr, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
